// File: rtl/bp_common_pkg.sv
// Shared processor configuration: parameter-set enum and the widths
// each configuration implies for the proc/mem interfaces.
package bp_common_pkg;

  typedef enum logic [0:0] {
    e_bp_default_cfg = 1'b0
  } bp_params_e;

  typedef struct packed {
    logic [15:0] paddr_width;
    logic [15:0] cce_block_width;
    logic [15:0] payload_width;
  } bp_proc_param_s;

  localparam bp_proc_param_s bp_default_cfg_p = '{
    paddr_width:     16'd40,
    cce_block_width: 16'd512,
    payload_width:   16'd16
  };

  function automatic bp_proc_param_s bp_get_cfg(
    input bp_params_e p
  );
    case (p)
      e_bp_default_cfg: return bp_default_cfg_p;
      default:          return bp_default_cfg_p;
    endcase
  endfunction

  localparam int paddr_width_gp =
    int'(bp_default_cfg_p.paddr_width);
  localparam int cce_block_width_gp =
    int'(bp_default_cfg_p.cce_block_width);
  localparam int payload_width_gp =
    int'(bp_default_cfg_p.payload_width);

  // Devices decode only the low 4 KiB of their page.
  localparam int dev_page_offset_width_gp = 12;

endpackage

// File: rtl/bp_me_pkg.sv
// Memory-end message formats, command/size encodings, the MMIO
// responder FSM states and byte-mask helpers.
package bp_me_pkg;

  import bp_common_pkg::*;

  typedef enum logic [3:0] {
    e_rd    = 4'b0000,
    e_wr    = 4'b0001,
    e_uc_rd = 4'b0010,
    e_uc_wr = 4'b0011
  } bp_cce_mem_cmd_type_e;

  typedef enum logic [2:0] {
    e_mem_msg_size_1  = 3'b000,
    e_mem_msg_size_2  = 3'b001,
    e_mem_msg_size_4  = 3'b010,
    e_mem_msg_size_8  = 3'b011,
    e_mem_msg_size_16 = 3'b100,
    e_mem_msg_size_32 = 3'b101,
    e_mem_msg_size_64 = 3'b110
  } bp_mem_msg_size_e;

  typedef struct packed {
    logic [payload_width_gp-1:0] payload;
    bp_mem_msg_size_e            size;
    logic [paddr_width_gp-1:0]   addr;
    bp_cce_mem_cmd_type_e        msg_type;
  } bp_cce_mem_msg_header_s;

  typedef struct packed {
    logic [cce_block_width_gp-1:0] data;
    bp_cce_mem_msg_header_s        header;
  } bp_cce_mem_msg_s;

  typedef enum logic {
    e_ready = 1'b0,
    e_resp  = 1'b1
  } bp_io_mmio_state_e;

  // Register 0 is the read-only error counter.
  localparam int bp_io_err_reg_idx_gp = 0;

  function automatic int cce_mem_msg_width(
    input bp_params_e p
  );
    bp_proc_param_s c;
    c = bp_get_cfg(p);
    return 7 + int'(c.paddr_width)
             + int'(c.payload_width)
             + int'(c.cce_block_width);
  endfunction

  // Sizes above 8 bytes clamp to the full 64-bit register.
  function automatic logic [7:0] size_bmask(
    input bp_mem_msg_size_e s
  );
    case (s)
      e_mem_msg_size_1: return 8'h01;
      e_mem_msg_size_2: return 8'h03;
      e_mem_msg_size_4: return 8'h0F;
      default:          return 8'hFF;
    endcase
  endfunction

  function automatic logic [63:0] byte_expand(
    input logic [7:0] m
  );
    logic [63:0] r;
    for (int i = 0; i < 8; i++)
      r[8*i +: 8] = {8{m[i]}};
    return r;
  endfunction

endpackage

// File: rtl/bp_io_mmio_regfile.sv
// 64-bit device registers with byte-merge writes, shifted/masked
// reads, and the saturating error counter behind register 0.
module bp_io_mmio_regfile
  import bp_me_pkg::*;
#(
  parameter int num_regs_p = 8,
  localparam int idx_w_lp = $clog2(num_regs_p)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic                err_inc,
  input  logic [idx_w_lp-1:0] idx,
  input  logic [2:0]          off,
  input  bp_mem_msg_size_e    size,
  input  logic [63:0]         wdata,
  output logic [63:0]         rdata
);

  logic [63:0] regs [1:num_regs_p-1];
  logic [15:0] err_cnt;
  logic [63:0] cur;
  logic [63:0] wmask;
  logic [63:0] rmask;
  logic [7:0]  wbm;
  logic [5:0]  sh;

  assign sh    = {off, 3'b000};
  // Bytes shifted past byte 7 fall off the 8-bit mask.
  assign wbm   = size_bmask(size) << off;
  assign wmask = byte_expand(wbm);
  assign rmask = byte_expand(size_bmask(size));

  always_comb begin
    cur = {48'b0, err_cnt};
    for (int i = 1; i < num_regs_p; i++)
      if (idx == idx_w_lp'(i))
        cur = regs[i];
  end

  assign rdata = (cur >> sh) & rmask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < num_regs_p; i++)
        regs[i] <= '0;
      err_cnt <= '0;
    end else begin
      for (int i = 1; i < num_regs_p; i++)
        if (we && idx == idx_w_lp'(i))
          regs[i] <= (regs[i] & ~wmask)
                   | ((wdata << sh) & wmask);
      if (err_inc && err_cnt != 16'hFFFF)
        err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/bp_io_mmio_responder.sv
// MMIO responder: accepts one IO command at a time, answers it one
// cycle later with the echoed header and register read data.
module bp_io_mmio_responder
  import bp_common_pkg::*;
  import bp_me_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  parameter int num_regs_p = 8,
  localparam int cce_mem_msg_width_lp =
    cce_mem_msg_width(bp_params_p)
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic [cce_mem_msg_width_lp-1:0] io_cmd_i,
  input  logic                            io_cmd_v_i,
  output logic                            io_cmd_yumi_o,
  output logic [cce_mem_msg_width_lp-1:0] io_resp_o,
  output logic                            io_resp_v_o,
  input  logic                            io_resp_ready_i
);

  localparam int idx_w_lp = $clog2(num_regs_p);
  localparam int pw_lp = dev_page_offset_width_gp;

  bp_io_mmio_state_e      state, state_n;
  bp_cce_mem_msg_s        cmd, resp;
  bp_cce_mem_msg_header_s hdr_r;
  logic [63:0]            data_r;
  logic [63:0]            rdata;
  logic [idx_w_lp-1:0]    idx;
  logic [2:0]             off;
  logic [pw_lp-1:0]       pg;
  logic                   oor, is_rd, is_wr, err;
  logic                   we, err_inc;
  logic                   unused_data;

  assign cmd   = io_cmd_i;
  assign idx   = cmd.header.addr[3 +: idx_w_lp];
  assign off   = cmd.header.addr[2:0];
  assign pg    = cmd.header.addr[pw_lp-1:0];
  // Any page-offset bit above the index field is a hole.
  assign oor   = |(pg >> (3 + idx_w_lp));
  assign is_rd = cmd.header.msg_type == e_uc_rd;
  assign is_wr = cmd.header.msg_type == e_uc_wr;
  assign err   = !(is_rd || is_wr) || oor;

  assign unused_data = ^cmd.data[cce_block_width_gp-1:64];

  assign we = io_cmd_yumi_o && is_wr && !oor
           && idx != idx_w_lp'(bp_io_err_reg_idx_gp);
  assign err_inc = io_cmd_yumi_o && err;

  always_comb begin
    state_n       = state;
    io_cmd_yumi_o = 1'b0;
    io_resp_v_o   = 1'b0;
    unique case (state)
      e_ready: begin
        io_cmd_yumi_o = io_cmd_v_i;
        if (io_cmd_v_i)
          state_n = e_resp;
      end
      e_resp: begin
        io_resp_v_o = 1'b1;
        if (io_resp_ready_i)
          state_n = e_ready;
      end
      default: state_n = e_ready;
    endcase
    // Handshakes drop the moment reset asserts, not at the edge.
    if (!reset_n_i) begin
      io_cmd_yumi_o = 1'b0;
      io_resp_v_o   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state  <= e_ready;
      hdr_r  <= '0;
      data_r <= '0;
    end else begin
      state <= state_n;
      if (io_cmd_yumi_o) begin
        hdr_r  <= cmd.header;
        data_r <= (is_rd && !oor) ? rdata : '0;
      end
    end
  end

  always_comb begin
    resp            = '0;
    resp.header     = hdr_r;
    resp.data[63:0] = data_r;
  end

  assign io_resp_o = resp;

  bp_io_mmio_regfile #(
    .num_regs_p(num_regs_p)
  ) u_regfile (
    .clk     (clk_i),
    .rst_n   (reset_n_i),
    .we      (we),
    .err_inc (err_inc),
    .idx     (idx),
    .off     (off),
    .size    (cmd.header.size),
    .wdata   (cmd.data[63:0]),
    .rdata   (rdata)
  );

endmodule

// File: tb/tb_bp_io_mmio_responder.sv
// Directed bench for bp_io_mmio_responder: handshake timing, byte
// merge/extract, error counting, saturation and async reset.
module tb_bp_io_mmio_responder;

  import bp_common_pkg::*;
  import bp_me_pkg::*;

  localparam int W = cce_mem_msg_width(e_bp_default_cfg);

  logic         clk = 1'b0;
  logic         reset_n_i;
  logic [W-1:0] io_cmd_i;
  logic         io_cmd_v_i;
  logic         io_cmd_yumi_o;
  logic [W-1:0] io_resp_o;
  logic         io_resp_v_o;
  logic         io_resp_ready_i;

  bp_cce_mem_msg_s resp_s;
  assign resp_s = io_resp_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bp_io_mmio_responder #(
    .bp_params_p(e_bp_default_cfg),
    .num_regs_p(8)
  ) dut (
    .clk_i           (clk),
    .reset_n_i       (reset_n_i),
    .io_cmd_i        (io_cmd_i),
    .io_cmd_v_i      (io_cmd_v_i),
    .io_cmd_yumi_o   (io_cmd_yumi_o),
    .io_resp_o       (io_resp_o),
    .io_resp_v_o     (io_resp_v_o),
    .io_resp_ready_i (io_resp_ready_i)
  );

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  function automatic bp_cce_mem_msg_s mk(
    input bp_cce_mem_cmd_type_e t,
    input logic [39:0]          a,
    input bp_mem_msg_size_e     s,
    input logic [63:0]          d
  );
    bp_cce_mem_msg_s m;
    m                 = '0;
    m.header.msg_type = t;
    m.header.addr     = a;
    m.header.size     = s;
    m.header.payload  = 16'hC0DE ^ a[15:0];
    m.data[63:0]      = d;
    m.data[127:64]    = 64'hDEAD_BEEF_CAFE_F00D;
    return m;
  endfunction

  // Entered and left #1 after a rising edge with the FSM idle.
  task automatic run(input string tag,
                     input bp_cce_mem_cmd_type_e t,
                     input logic [39:0] a,
                     input bp_mem_msg_size_e s,
                     input logic [63:0] wd,
                     input logic [63:0] exp);
    bp_cce_mem_msg_s c;
    c = mk(t, a, s, wd);
    io_cmd_i   = c;
    io_cmd_v_i = 1'b1;
    @(negedge clk);
    chk({tag, ".yumi"}, 128'(io_cmd_yumi_o), 128'(1));
    @(posedge clk);
    #1 io_cmd_v_i = 1'b0;
    @(negedge clk);
    chk({tag, ".v"}, 128'(io_resp_v_o), 128'(1));
    chk({tag, ".hdr"}, 128'(resp_s.header),
        128'(c.header));
    chk({tag, ".hi"}, 128'(|resp_s.data[511:64]), 128'(0));
    chk({tag, ".d"}, 128'(resp_s.data[63:0]), 128'(exp));
    io_resp_ready_i = 1'b1;
    @(posedge clk);
    #1 io_resp_ready_i = 1'b0;
  endtask

  logic [W-1:0]    held;
  bp_cce_mem_msg_s wc;

  initial begin
    reset_n_i       = 1'b0;
    io_resp_ready_i = 1'b0;
    io_cmd_i        = mk(e_uc_rd, 40'h8, e_mem_msg_size_8, '0);
    io_cmd_v_i      = 1'b1;
    #3;
    chk("rst.yumi", 128'(io_cmd_yumi_o), 128'(0));
    chk("rst.v", 128'(io_resp_v_o), 128'(0));
    io_cmd_v_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n_i = 1'b1;

    run("rst_rd1", e_uc_rd, 40'h8, e_mem_msg_size_8,
        64'hFFFF_FFFF_FFFF_FFFF, 64'h0);

    run("wr1", e_uc_wr, 40'h8, e_mem_msg_size_8,
        64'h1122334455667788, 64'h0);
    run("rd1", e_uc_rd, 40'h8, e_mem_msg_size_8,
        64'hFFFF_FFFF_FFFF_FFFF, 64'h1122334455667788);
    run("rd1_o1s4", e_uc_rd, 40'h9, e_mem_msg_size_4,
        '0, 64'h44556677);

    run("wr2", e_uc_wr, 40'h14, e_mem_msg_size_2,
        64'h1234_5678_9ABC_BEEF, 64'h0);
    run("rd2", e_uc_rd, 40'h10, e_mem_msg_size_8,
        '0, 64'h0000BEEF00000000);
    run("rd2_o4s2", e_uc_rd, 40'h14, e_mem_msg_size_2,
        '0, 64'hBEEF);

    run("wr3_trunc", e_uc_wr, 40'h1E, e_mem_msg_size_4,
        64'hAABBCCDD, 64'h0);
    run("rd3", e_uc_rd, 40'h18, e_mem_msg_size_8,
        '0, 64'hCCDD000000000000);

    // Response held back while a second command waits.
    io_cmd_i   = mk(e_uc_rd, 40'h8, e_mem_msg_size_8, '0);
    io_cmd_v_i = 1'b1;
    @(negedge clk);
    chk("stall.yumi0", 128'(io_cmd_yumi_o), 128'(1));
    @(posedge clk);
    wc = mk(e_uc_wr, 40'h20, e_mem_msg_size_8, 64'h55);
    #1 io_cmd_i = wc;
    @(negedge clk);
    held = io_resp_o;
    chk("stall.d", 128'(resp_s.data[63:0]),
        128'(64'h1122334455667788));
    for (int i = 0; i < 5; i++) begin
      chk("stall.yumi", 128'(io_cmd_yumi_o), 128'(0));
      chk("stall.v", 128'(io_resp_v_o), 128'(1));
      chk("stall.hold", 128'(io_resp_o === held), 128'(1));
      @(negedge clk);
    end
    io_resp_ready_i = 1'b1;
    @(posedge clk);
    #1 io_resp_ready_i = 1'b0;
    @(negedge clk);
    chk("stall.yumi1", 128'(io_cmd_yumi_o), 128'(1));
    @(posedge clk);
    #1 io_cmd_v_i = 1'b0;
    @(negedge clk);
    chk("stall.wv", 128'(io_resp_v_o), 128'(1));
    chk("stall.whdr", 128'(resp_s.header),
        128'(wc.header));
    chk("stall.wd", 128'(resp_s.data[63:0]), 128'(0));
    io_resp_ready_i = 1'b1;
    @(posedge clk);
    #1 io_resp_ready_i = 1'b0;
    run("rd4", e_uc_rd, 40'h20, e_mem_msg_size_8,
        '0, 64'h55);

    run("err0", e_uc_rd, 40'h0, e_mem_msg_size_8, '0, 64'h0);
    run("wr_r0", e_uc_wr, 40'h0, e_mem_msg_size_8,
        64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
    run("blk_rd", e_rd, 40'h40, e_mem_msg_size_64,
        '0, 64'h0);
    run("oor_rd", e_uc_rd, 40'h48, e_mem_msg_size_8,
        '0, 64'h0);
    run("err2", e_uc_rd, 40'h0, e_mem_msg_size_8, '0, 64'h2);
    run("oor_wr", e_uc_wr, 40'h48, e_mem_msg_size_8,
        64'h0, 64'h0);
    run("rd1_kept", e_uc_rd, 40'h8, e_mem_msg_size_8,
        '0, 64'h1122334455667788);
    run("err3", e_uc_rd, 40'h0, e_mem_msg_size_8, '0, 64'h3);

    // Jump the counter to the brink instead of replaying 65535
    // erroneous commands.
    dut.u_regfile.err_cnt = 16'hFFFE;
    run("blk_wr", e_wr, 40'h0, e_mem_msg_size_64, '0, 64'h0);
    run("sat1", e_uc_rd, 40'h0, e_mem_msg_size_8,
        '0, 64'hFFFF);
    run("blk_rd2", e_rd, 40'h0, e_mem_msg_size_64, '0, 64'h0);
    run("sat2", e_uc_rd, 40'h0, e_mem_msg_size_8,
        '0, 64'hFFFF);
    run("sat_s1", e_uc_rd, 40'h1, e_mem_msg_size_1,
        '0, 64'hFF);

    // Async reset while a response is pending.
    io_cmd_i   = mk(e_uc_rd, 40'h8, e_mem_msg_size_8, '0);
    io_cmd_v_i = 1'b1;
    @(negedge clk);
    chk("ar.yumi", 128'(io_cmd_yumi_o), 128'(1));
    @(posedge clk);
    @(negedge clk);
    chk("ar.v1", 128'(io_resp_v_o), 128'(1));
    #2 reset_n_i = 1'b0;
    #1;
    chk("ar.v0", 128'(io_resp_v_o), 128'(0));
    chk("ar.yumi0", 128'(io_cmd_yumi_o), 128'(0));
    io_cmd_v_i = 1'b0;
    @(posedge clk);
    #1 reset_n_i = 1'b1;
    @(negedge clk);
    chk("ar.drop", 128'(io_resp_v_o), 128'(0));
    @(posedge clk);
    #1;
    run("ar.rd1", e_uc_rd, 40'h8, e_mem_msg_size_8,
        '0, 64'h0);
    run("ar.rd2", e_uc_rd, 40'h10, e_mem_msg_size_8,
        '0, 64'h0);
    run("ar.err", e_uc_rd, 40'h0, e_mem_msg_size_8,
        '0, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bp_io_mmio_responder.md
BP_IO_MMIO_RESPONDER -- requirements
Module: bp_io_mmio_responder

Interface
REQ-001 SHALL have parameter bp_params_p, default e_bp_default_cfg; proc/mem-if widths are derived from it.
REQ-002 SHALL have parameter num_regs_p, default 8; number of 64-bit device registers, power of two, >= 2.
REQ-003 SHALL have port clk_i, input, 1 bit; the single clock.
REQ-004 SHALL have port reset_n_i, input, 1 bit; reset, asynchronous and active-low.
REQ-005 SHALL have port io_cmd_i, input, cce_mem_msg_width_lp bits; incoming IO command (bp_cce_mem_msg_s).
REQ-006 SHALL have port io_cmd_v_i, input, 1 bit; command valid.
REQ-007 SHALL have port io_cmd_yumi_o, output, 1 bit; command consumed this cycle.
REQ-008 SHALL have port io_resp_o, output, cce_mem_msg_width_lp bits; IO response (bp_cce_mem_msg_s).
REQ-009 SHALL have port io_resp_v_o, output, 1 bit; response valid.
REQ-010 SHALL have port io_resp_ready_i, input, 1 bit; response accepted when high with io_resp_v_o.

Function
REQ-011 SHALL implement a two-state FSM: e_ready, then e_resp.
- e_ready -> e_resp on io_cmd_v_i.
- e_resp -> e_ready on io_resp_ready_i.
REQ-012 SHALL assert io_cmd_yumi_o = io_cmd_v_i in e_ready, and 0 in e_resp.
- One command outstanding at a time.
- The yumi depends only on state and v_i, never on io_resp_ready_i.
REQ-013 SHALL register the command header on acceptance and hold io_resp_v_o = 1 in e_resp.
- Response valid in the cycle after acceptance: latency 1.
- io_resp_o stays stable until accepted.
REQ-014 SHALL drive the response header equal to the accepted command header (msg_type, addr, size, payload unchanged).
REQ-015 SHALL decode the register index as addr[3 +: log2(num_regs_p)], the byte offset as addr[2:0], and the size as 1/2/4/8 bytes.
REQ-016 SHALL treat an address as out-of-range when its address bits above the index field, within the device page, are nonzero.
REQ-017 On e_uc_wr to an in-range register other than 0, SHALL merge the low size bytes of io_cmd_i.data into the register at the byte offset.
- Bytes beyond byte 7 are truncated.
- The register updates on the acceptance edge.
REQ-018 On e_uc_rd, SHALL return the register shifted right by 8*offset, zero-extended above size bytes.
- The result is placed in data[63:0], with the upper response data bits 0.
- The value is sampled at the acceptance edge.
REQ-019 Register 0 SHALL be read-only and return {48'b0, err_cnt}; writes to it SHALL be dropped and SHALL NOT count as errors.
REQ-020 Unsupported msg_type (any other than e_uc_rd/e_uc_wr) or an out-of-range address SHALL:
- still be consumed and answered;
- return zero data;
- drop any write;
- increment err_cnt.
REQ-021 err_cnt SHALL be 16 bits, saturating at 16'hFFFF, never wrapping.
REQ-022 A write response SHALL carry zero data.
REQ-023 A register read in the cycle after a write to the same register SHALL see the new value.

Reset
REQ-024 On reset_n_i low, SHALL immediately, asynchronously and regardless of clock:
- set state to e_ready;
- drive io_resp_v_o=0 and io_cmd_yumi_o=0;
- clear all registers and err_cnt to 0.
REQ-025 A response pending at reset assertion SHALL be discarded, not replayed.
REQ-026 SHALL accept a command in the first clock edge after reset deasserts.

Structure
REQ-027 SHALL keep bp_cce_mem_msg_s, e_uc_rd and e_uc_wr in the shared bp_common/bp_me packages.
REQ-028 SHALL add the FSM enum and the err-register index constant to bp_me_pkg.
REQ-029 SHALL implement the register file and byte-merge as one sub-module, bp_io_mmio_regfile; the FSM and response formation stay in the top.

Verification
REQ-030 SHALL cover: uc_wr size 8, reg 1, data 64'h1122334455667788 -> yumi same cycle; resp_v next cycle with data 0; a following uc_rd size 8, reg 1 returns 64'h1122334455667788.
REQ-031 SHALL cover: uc_wr size 2, reg 2, offset 4, data 16'hBEEF onto 64'h0 -> uc_rd size 8 returns 64'h0000BEEF00000000; uc_rd size 2, offset 4 returns 64'hBEEF.
REQ-032 SHALL cover: io_resp_ready_i held low 5 cycles with a pending response and io_cmd_v_i high -> yumi stays 0 and io_resp_o stays stable; one cmd accepted the cycle after ready.
REQ-033 SHALL cover: e_uc_wr to reg 0, then a cache-block e_rd, then an out-of-range address -> all three answered; err_cnt reads 2 via reg 0.
REQ-034 SHALL cover: err_cnt preset by 65537 errors -> reads 16'hFFFF, no wrap.
REQ-035 SHALL cover: reset_n_i low mid-e_resp, between edges -> io_resp_v_o falls without a clock edge; reg 1 then reads 0.
